y86_fetch_stage: RTL and testbench
==================================

# y86_fetch_stage

Fetch stage of the Y86-64 five-stage pipeline, directly upstream of instruction memory. It owns the predicted-PC register and selects the fetch PC from the prediction, a mispredicted-branch correction or a `ret` return address. It drives the memory read address, splits the 80-bit little-endian instruction window into fields and computes `valP` and the next prediction. It captures the fetched instruction in the F/D pipeline register, which has stall and bubble control.

## Interface
- No parameters.
- `clk_i` in 1: clock; all state on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `f_stall_i` in 1: hold the predicted-PC register.
- `d_stall_i` in 1: hold the F/D register.
- `d_bubble_i` in 1: load a NOP bubble into F/D.
- `M_icode_i` in 4: icode in the memory stage.
- `M_cnd_i` in 1: branch condition in the memory stage.
- `M_valA_i` in 64: fall-through PC of the jump in the memory stage.
- `W_icode_i` in 4: icode in the write-back stage.
- `W_valM_i` in 64: return address popped by `ret`.
- `imem_raddr_o` out 64: instruction memory byte address (combinational).
- `imem_rdata_i` in 80: bytes `[raddr+9 .. raddr]`, with byte 0 in `[7:0]`.
- `imem_error_i` in 1: address out of range.
- `D_stat_o` out 3: status (AOK=1, HLT=2, ADR=3, INS=4).
- `D_icode_o`, `D_ifun_o`, `D_rA_o`, `D_rB_o` out 4 each.
- `D_valC_o`, `D_valP_o`, `D_pc_o` out 64 each.

## Operation
- **PC select (combinational)**, first match wins:
  - `M_icode_i`==7 and `!M_cnd_i` → `M_valA_i`.
  - `W_icode_i`==9 → `W_valM_i`.
  - Otherwise → `predPC`.
  - `imem_raddr_o` = f_pc.
- **Byte 0 split:** icode=`rdata[7:4]`, ifun=`rdata[3:0]`.
- **`imem_error_i`:** forces icode=1, ifun=0, stat=ADR.
- **Validity:** icode 0..B valid. Any other icode gives stat=INS; the fields still pass through.
- **Status:** icode 0 gives stat=HLT. Otherwise stat=AOK.
- **need_regids:** icode ∈ {2,3,4,5,6,A,B}. When set, rA=`rdata[15:12]` and rB=`rdata[11:8]`; otherwise both are 0xF.
- **need_valC:** icode ∈ {3,4,5,7,8}. valC=`rdata[79:16]` if need_regids, else `rdata[71:8]`. valC=0 when need_valC is clear.
- **valP** = f_pc + 1 + need_regids + 8·need_valC, modulo 2^64 (wrap silently).
- **Next prediction:** icode ∈ {7,8} → valC; else valP.
- **Predicted-PC register:**
  - Reset → 0.
  - `!f_stall_i` → load the next prediction.
  - `f_stall_i` → hold.
- **F/D register:**
  - Reset or (`d_bubble_i` and `!d_stall_i`) → bubble: stat=1, icode=1, ifun=0, rA=rB=0xF, valC=valP=pc=0.
  - `d_stall_i` → hold. Stall wins over bubble.
  - Otherwise → load the fetched fields, with `D_pc_o`=f_pc.
- The memory returns 0 for addresses 1017..1023 without raising an error. The block decodes such bytes as `halt`; no extra check.

## Timing
- Combinational path: predPC/M/W inputs → `imem_raddr_o` → `imem_rdata_i` → F/D D-inputs, all within one cycle.
- Latency: an instruction at f_pc appears on the `D_*` outputs one rising edge after f_pc is presented.
- A correction (mispredict or `ret`) takes effect in the same cycle it is asserted. The following edge loads F/D with the instruction at the corrected PC.
- Reset asserted mid-operation: the next edge gives predPC=0 and a bubble in F/D, regardless of stall or bubble inputs.
- Outputs after reset: `imem_raddr_o`=0 (absent M/W overrides); `D_*` hold bubble values.

## Configuration
- **`FETCH_IFUN_CHECK_EN` defined:** ifun is also validated.
  - icode 2 and 7 require ifun ≤ 6.
  - icode 6 requires ifun ≤ 3.
  - All other valid icodes require ifun = 0.
  - A violation gives stat=INS.
- **Undefined:** ifun is not checked; only icode decides INS.

## Test plan
- **Reset, then memory bytes 30 F1 01 00 00 00 00 00 00 00 at address 0:** after one edge, D_icode=3, ifun=0, rA=F, rB=1, valC=1, valP=10, stat=1. Next `imem_raddr_o`=10.
- **`jmp` bytes 70 30 00.. at pc 38:** D_valC=0x30, D_valP=47. Next `imem_raddr_o`=0x30.
- **M_icode=7, M_cnd=0, M_valA=0x2F while predPC=0x30:** `imem_raddr_o`=0x2F in the same cycle. With W_icode=9 and W_valM=0x100 also asserted, the address is still 0x2F (mispredict priority). With M_cnd=1, the address is 0x100.
- **Fetch at address 1024 (imem_error=1):** D_stat=3, D_icode=1. Address 1017 with zero bytes gives D_stat=2, icode=0.
- **Stall/bubble:**
  - f_stall=1 and d_stall=1 for 2 cycles: predPC and all `D_*` unchanged.
  - d_bubble=1 alone: D_icode=1, rA=rB=F.
  - d_bubble=1 with d_stall=1: D outputs hold.
- **Reset mid-stream at pc 40, and ifun check:** one edge of rst_i gives `imem_raddr_o`=0 and a bubble in F/D. Bytes 6F 12: D_stat=4 with `FETCH_IFUN_CHECK_EN` defined, D_stat=1 without.

Source files
------------

// File: rtl/y86_fetch_stage.sv
// Y86-64 fetch stage: PC select, instruction split, predicted-PC register and F/D register.
// Optional build macro FETCH_IFUN_CHECK_EN additionally validates ifun per icode.
module y86_fetch_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        f_stall_i,
    input  logic        d_stall_i,
    input  logic        d_bubble_i,
    input  logic [3:0]  M_icode_i,
    input  logic        M_cnd_i,
    input  logic [63:0] M_valA_i,
    input  logic [3:0]  W_icode_i,
    input  logic [63:0] W_valM_i,
    output logic [63:0] imem_raddr_o,
    input  logic [79:0] imem_rdata_i,
    input  logic        imem_error_i,
    output logic [2:0]  D_stat_o,
    output logic [3:0]  D_icode_o,
    output logic [3:0]  D_ifun_o,
    output logic [3:0]  D_rA_o,
    output logic [3:0]  D_rB_o,
    output logic [63:0] D_valC_o,
    output logic [63:0] D_valP_o,
    output logic [63:0] D_pc_o
);

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;

    logic [63:0] pred_pc;
    logic [63:0] f_pc;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_ra;
    logic [3:0]  f_rb;
    logic [63:0] f_valc;
    logic [63:0] f_valp;
    logic [63:0] f_pred;
    logic        need_regids;
    logic        need_valc;
    logic        instr_valid;
    logic        ifun_valid;
    stat_e       f_stat;

    // A not-taken jump in M outranks a ret in W; both override the prediction.
    always_comb begin
        if (M_icode_i == I_JXX && !M_cnd_i) begin
            f_pc = M_valA_i;
        end else if (W_icode_i == I_RET) begin
            f_pc = W_valM_i;
        end else begin
            f_pc = pred_pc;
        end
    end

    assign imem_raddr_o = f_pc;

    // A bad fetch address is turned into a nop so nothing downstream acts on garbage bytes.
    always_comb begin
        if (imem_error_i) begin
            f_icode = I_NOP;
            f_ifun  = 4'h0;
        end else begin
            f_icode = imem_rdata_i[7:4];
            f_ifun  = imem_rdata_i[3:0];
        end
    end

    assign instr_valid = (f_icode <= I_POPQ);

`ifdef FETCH_IFUN_CHECK_EN
    always_comb begin
        case (f_icode)
            I_RRMOVQ, I_JXX: ifun_valid = (f_ifun <= 4'd6);
            I_OPQ:           ifun_valid = (f_ifun <= 4'd3);
            default:         ifun_valid = (f_ifun == 4'd0);
        endcase
    end
`else
    assign ifun_valid = 1'b1;
`endif

    always_comb begin
        if (imem_error_i) begin
            f_stat = STAT_ADR;
        end else if (!instr_valid || !ifun_valid) begin
            f_stat = STAT_INS;
        end else if (f_icode == I_HALT) begin
            f_stat = STAT_HLT;
        end else begin
            f_stat = STAT_AOK;
        end
    end

    always_comb begin
        case (f_icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
            default:                need_regids = 1'b0;
        endcase
        case (f_icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_JXX, I_CALL:          need_valc = 1'b1;
            default:                need_valc = 1'b0;
        endcase
    end

    // The constant sits right after the register byte when there is one.
    always_comb begin
        if (need_regids) begin
            f_ra = imem_rdata_i[15:12];
            f_rb = imem_rdata_i[11:8];
        end else begin
            f_ra = REG_NONE;
            f_rb = REG_NONE;
        end
        if (!need_valc) begin
            f_valc = 64'd0;
        end else if (need_regids) begin
            f_valc = imem_rdata_i[79:16];
        end else begin
            f_valc = imem_rdata_i[71:8];
        end
    end

    always_comb begin
        f_valp = f_pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
        if (f_icode == I_JXX || f_icode == I_CALL) begin
            f_pred = f_valc;
        end else begin
            f_pred = f_valp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pred_pc <= 64'd0;
        end else if (!f_stall_i) begin
            pred_pc <= f_pred;
        end
    end

    // Stall dominates bubble; reset always forces a bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i || (d_bubble_i && !d_stall_i)) begin
            D_stat_o  <= STAT_AOK;
            D_icode_o <= I_NOP;
            D_ifun_o  <= 4'h0;
            D_rA_o    <= REG_NONE;
            D_rB_o    <= REG_NONE;
            D_valC_o  <= 64'd0;
            D_valP_o  <= 64'd0;
            D_pc_o    <= 64'd0;
        end else if (!d_stall_i) begin
            D_stat_o  <= f_stat;
            D_icode_o <= f_icode;
            D_ifun_o  <= f_ifun;
            D_rA_o    <= f_ra;
            D_rB_o    <= f_rb;
            D_valC_o  <= f_valc;
            D_valP_o  <= f_valp;
            D_pc_o    <= f_pc;
        end
    end

endmodule

// File: tb/tb_y86_fetch_stage.sv
// Self-checking bench for y86_fetch_stage: directed test-plan steps, then randomized cycles
// checked against an instruction-length based reference model of fetch.
module tb_y86_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        f_stall_i;
    logic        d_stall_i;
    logic        d_bubble_i;
    logic [3:0]  M_icode_i;
    logic        M_cnd_i;
    logic [63:0] M_valA_i;
    logic [3:0]  W_icode_i;
    logic [63:0] W_valM_i;
    logic [63:0] imem_raddr_o;
    logic [79:0] imem_rdata_i;
    logic        imem_error_i;
    logic [2:0]  D_stat_o;
    logic [3:0]  D_icode_o;
    logic [3:0]  D_ifun_o;
    logic [3:0]  D_rA_o;
    logic [3:0]  D_rB_o;
    logic [63:0] D_valC_o;
    logic [63:0] D_valP_o;
    logic [63:0] D_pc_o;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
        logic [63:0] pc;
    } dreg_t;

    logic [7:0] mem [0:1023];
    int         insnLen  [0:11] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2};
    int         maxIfun  [0:11] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0};
    int         checks   = 0;
    int         failures = 0;
    logic [63:0] mPred;
    dreg_t       mD;
    bit          mValid = 1'b0;

    always #5 clk_i = ~clk_i;

    y86_fetch_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .f_stall_i    (f_stall_i),
        .d_stall_i    (d_stall_i),
        .d_bubble_i   (d_bubble_i),
        .M_icode_i    (M_icode_i),
        .M_cnd_i      (M_cnd_i),
        .M_valA_i     (M_valA_i),
        .W_icode_i    (W_icode_i),
        .W_valM_i     (W_valM_i),
        .imem_raddr_o (imem_raddr_o),
        .imem_rdata_i (imem_rdata_i),
        .imem_error_i (imem_error_i),
        .D_stat_o     (D_stat_o),
        .D_icode_o    (D_icode_o),
        .D_ifun_o     (D_ifun_o),
        .D_rA_o       (D_rA_o),
        .D_rB_o       (D_rB_o),
        .D_valC_o     (D_valC_o),
        .D_valP_o     (D_valP_o),
        .D_pc_o       (D_pc_o)
    );

    // 1 KiB instruction memory; bytes past the end read as zero, addresses >= 1024 fault.
    always_comb begin
        imem_rdata_i = '0;
        imem_error_i = (imem_raddr_o >= 64'd1024);
        for (int k = 0; k < 10; k++) begin
            if (!imem_error_i && (imem_raddr_o + 64'(k)) < 64'd1024)
                imem_rdata_i[k*8 +: 8] = mem[10'(imem_raddr_o + 64'(k))];
        end
    end

    function automatic logic [7:0] memByte(input logic [63:0] a);
        return (a < 64'd1024) ? mem[a[9:0]] : 8'h00;
    endfunction

    function automatic dreg_t bubbleVal();
        dreg_t b;
        b.stat = 3'd1; b.icode = 4'h1; b.ifun = 4'h0; b.rA = 4'hF; b.rB = 4'hF;
        b.valC = '0;   b.valP = '0;    b.pc = '0;
        return b;
    endfunction

    function automatic bit ifunOk(input logic [3:0] icode, input logic [3:0] ifun);
`ifdef FETCH_IFUN_CHECK_EN
        return (int'(ifun) <= maxIfun[icode]);
`else
        return 1'b1;
`endif
    endfunction

    // Decode by instruction length: 2 and 10 byte forms carry a register byte,
    // 9 and 10 byte forms end in an 8-byte constant.
    function automatic void fetchModel(input logic [63:0] pc, output dreg_t d, output logic [63:0] pred);
        int         len;
        logic [7:0] b0;
        logic [7:0] b1;
        d.pc = pc; d.rA = 4'hF; d.rB = 4'hF; d.valC = '0;
        if (pc >= 64'd1024) begin
            d.stat = 3'd3; d.icode = 4'h1; d.ifun = 4'h0;
            d.valP = pc + 64'd1;
            pred = d.valP;
            return;
        end
        b0 = memByte(pc);
        d.icode = b0[7:4];
        d.ifun  = b0[3:0];
        len = (d.icode <= 4'hB) ? insnLen[d.icode] : 1;
        if (len == 2 || len == 10) begin
            b1 = memByte(pc + 64'd1);
            d.rA = b1[7:4];
            d.rB = b1[3:0];
        end
        if (len >= 9) begin
            for (int i = 7; i >= 0; i--)
                d.valC = {d.valC[55:0], memByte(pc + 64'(len - 8 + i))};
        end
        d.valP = pc + 64'(len);
        if (d.icode > 4'hB || !ifunOk(d.icode, d.ifun)) d.stat = 3'd4;
        else if (d.icode == 4'h0)                        d.stat = 3'd2;
        else                                             d.stat = 3'd1;
        pred = (d.icode == 4'h7 || d.icode == 4'h8) ? d.valC : d.valP;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkD();
        checkOutput("D_stat",  64'(D_stat_o),  64'(mD.stat));
        checkOutput("D_icode", 64'(D_icode_o), 64'(mD.icode));
        checkOutput("D_ifun",  64'(D_ifun_o),  64'(mD.ifun));
        checkOutput("D_rA",    64'(D_rA_o),    64'(mD.rA));
        checkOutput("D_rB",    64'(D_rB_o),    64'(mD.rB));
        checkOutput("D_valC",  D_valC_o,       mD.valC);
        checkOutput("D_valP",  D_valP_o,       mD.valP);
        checkOutput("D_pc",    D_pc_o,         mD.pc);
    endtask

    // One clock: drive inputs, check the fetch address, advance the model, check F/D.
    task automatic applyStimulus(input logic rst, input logic fst, input logic dst, input logic dbub,
                                 input logic [3:0] mic, input logic mcnd, input logic [63:0] mva,
                                 input logic [3:0] wic, input logic [63:0] wvm);
        dreg_t       fd;
        logic [63:0] fpred;
        logic [63:0] fpc;
        rst_i = rst; f_stall_i = fst; d_stall_i = dst; d_bubble_i = dbub;
        M_icode_i = mic; M_cnd_i = mcnd; M_valA_i = mva;
        W_icode_i = wic; W_valM_i = wvm;
        #1;
        if (mic == 4'h7 && !mcnd) fpc = mva;
        else if (wic == 4'h9)     fpc = wvm;
        else                      fpc = mPred;
        if (mValid) checkOutput("raddr", imem_raddr_o, fpc);
        fetchModel(fpc, fd, fpred);
        if (rst) begin
            mPred  = '0;
            mD     = bubbleVal();
            mValid = 1'b1;
        end else begin
            if (!fst) mPred = fpred;
            if (!dst) mD = dbub ? bubbleVal() : fd;
        end
        @(posedge clk_i);
        #1;
        checkD();
    endtask

    task automatic stepIdle(input logic rst, input logic fst, input logic dst, input logic dbub);
        applyStimulus(rst, fst, dst, dbub, 4'h0, 1'b0, 64'd0, 4'h0, 64'd0);
    endtask

    task automatic stepRedirect(input logic [63:0] target);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 1'b0, target, 4'h0, 64'd0);
    endtask

    task automatic probeAddr(input string tag, input logic mcnd, input logic [63:0] mva,
                             input logic [3:0] wic, input logic [63:0] wvm, input logic [63:0] exp);
        M_icode_i = 4'h7; M_cnd_i = mcnd; M_valA_i = mva;
        W_icode_i = wic;  W_valM_i = wvm;
        #1;
        checkOutput(tag, imem_raddr_o, exp);
    endtask

    initial begin
        logic [3:0]  mic;
        logic        mcnd;
        logic [63:0] mva;
        logic [3:0]  wic;
        logic [63:0] wvm;
        int          r;

        for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
        mem[0] = 8'h30; mem[1] = 8'hF1; mem[2] = 8'h01;
        mem[38] = 8'h70; mem[39] = 8'h30;
        mem[200] = 8'h6F; mem[201] = 8'h12;
        for (int a = 300; a <= 1010; a++) mem[a] = 8'($urandom);

        // Reset, then irmovq $1, %rcx at address 0.
        stepIdle(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_raddr", imem_raddr_o, 64'd0);
        stepIdle(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("tp1_icode", 64'(D_icode_o), 64'd3);
        checkOutput("tp1_rA",    64'(D_rA_o),    64'hF);
        checkOutput("tp1_rB",    64'(D_rB_o),    64'd1);
        checkOutput("tp1_valC",  D_valC_o,       64'd1);
        checkOutput("tp1_valP",  D_valP_o,       64'd10);
        checkOutput("tp1_next",  imem_raddr_o,   64'd10);

        // jmp 0x30 at pc 38, reached through a mispredict correction.
        stepRedirect(64'd38);
        checkOutput("jmp_valC", D_valC_o, 64'h30);
        checkOutput("jmp_valP", D_valP_o, 64'd47);
        M_icode_i = 4'h0; W_icode_i = 4'h0;
        #1;
        checkOutput("jmp_next", imem_raddr_o, 64'h30);

        // Same-cycle PC selection priority.
        probeAddr("sel_mispredict", 1'b0, 64'h2F, 4'h0, 64'h100, 64'h2F);
        probeAddr("sel_both",       1'b0, 64'h2F, 4'h9, 64'h100, 64'h2F);
        probeAddr("sel_ret",        1'b1, 64'h2F, 4'h9, 64'h100, 64'h100);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 1'b1, 64'h2F, 4'h9, 64'h100);
        checkOutput("ret_pc", D_pc_o, 64'h100);

        // Out-of-range fetch and the zero-filled tail of memory.
        stepRedirect(64'd1024);
        checkOutput("adr_stat",  64'(D_stat_o),  64'd3);
        checkOutput("adr_icode", 64'(D_icode_o), 64'd1);
        stepRedirect(64'd1017);
        checkOutput("tail_stat",  64'(D_stat_o),  64'd2);
        checkOutput("tail_icode", 64'(D_icode_o), 64'd0);

        // Stall and bubble control.
        stepIdle(1'b0, 1'b1, 1'b1, 1'b0);
        stepIdle(1'b0, 1'b1, 1'b1, 1'b0);
        stepIdle(1'b0, 1'b0, 1'b0, 1'b0);
        stepIdle(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("bub_icode", 64'(D_icode_o), 64'd1);
        checkOutput("bub_rA",    64'(D_rA_o),    64'hF);
        checkOutput("bub_rB",    64'(D_rB_o),    64'hF);
        stepIdle(1'b0, 1'b0, 1'b0, 1'b0);
        stepIdle(1'b0, 1'b0, 1'b1, 1'b1);

        // Reset mid-stream overrides stall and bubble.
        stepRedirect(64'd40);
        stepIdle(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("midrst_raddr", imem_raddr_o, 64'd0);
        checkOutput("midrst_icode", 64'(D_icode_o), 64'd1);

        // opq with out-of-range ifun.
        stepRedirect(64'd200);
`ifdef FETCH_IFUN_CHECK_EN
        checkOutput("ifun_stat", 64'(D_stat_o), 64'd4);
`else
        checkOutput("ifun_stat", 64'(D_stat_o), 64'd1);
`endif
        checkOutput("ifun_rA", 64'(D_rA_o), 64'd1);
        checkOutput("ifun_rB", 64'(D_rB_o), 64'd2);

        // Randomized cycles over the random code region.
        for (int n = 0; n < 400; n++) begin
            r    = int'($urandom_range(0, 9));
            mva  = 64'($urandom_range(300, 1030));
            wvm  = 64'($urandom_range(0, 1030));
            mic  = 4'($urandom_range(0, 15));
            mcnd = 1'($urandom);
            wic  = 4'($urandom_range(0, 15));
            if (mPred > 64'd1030 || r == 0) begin
                mic = 4'h7; mcnd = 1'b0;
            end else if (r == 1) begin
                wic = 4'h9;
                if (mic == 4'h7) mcnd = 1'b1;
            end else if (r == 2) begin
                mva = {$urandom, $urandom};
                wvm = {$urandom, $urandom};
            end else begin
                if (mic == 4'h7) mcnd = 1'b1;
                if (wic == 4'h9) wic = 4'h0;
            end
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                          mic, mcnd, mva, wic, wvm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
